bch_stim_gen: RTL
=================

// Module: bch_stim_gen
// PURPOSE
//  Self-checking stimulus source for the BCH encode/decode sim loop. Generates
//  pseudo-random data words plus exact-weight error patterns and issues them
//  through the encode_start/busy handshake. Also counts issued tests, latches
//  the loop's sticky wrong flag and reports done/fail after a final drain.
// PARAMETERS
//  P           `BCH_SANE  BCH parameter bundle; B=`BCH_DATA_BITS(P), C=`BCH_CODE_BITS(P), T=`BCH_T(P)
//  SEED        32'h1      LFSR reset value; 0 is illegal, substitute 32'h1
//  MAX_ERR     T          highest error weight generated (0..T), must be < C
//  N_TESTS     64         number of codewords to issue (>=1)
//  DRAIN       4*C        cycles waited after the last issue before done
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  enable        in   1   run; low holds FSM in IDLE/WAIT states
//  busy          in   1   encoder busy from the loop
//  wrong         in   1   loop checker flag (sticky in loop, sampled here)
//  data_in       out  B   data word for the encoder, stable while start high
//  error         out  C   bit-flip pattern, popcount == err_weight
//  encode_start  out  1   one-cycle issue pulse
//  err_weight    out  8   weight of the pattern currently presented
//  test_count    out  32  tests issued so far
//  done          out  1   all tests issued and drained (sticky until reset)
//  fail          out  1   wrong seen high at any cycle after reset (sticky)
// BEHAVIOUR
//  Reset: all outputs 0, lfsr=SEED, FSM=IDLE, internal counters 0.
//  LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1 (mask 32'h80200003); advances
//   exactly once per cycle in GEN_DATA and GEN_ERR only; frozen elsewhere.
//  FSM:
//   IDLE     -> GEN_DATA when enable.
//   GEN_DATA fills data_in 32 bits/cycle LSB-first, ceil(B/32) cycles; clear
//            error; err_weight = test_count mod (MAX_ERR+1). -> GEN_ERR.
//   GEN_ERR  one candidate per cycle: pos = lfsr[log2(C)-1:0]; reject if
//            pos>=C or error[pos] already set; else set bit, placed++.
//            placed==err_weight (incl. weight 0, zero cycles) -> ISSUE.
//   ISSUE    wait until busy==0 && enable; then encode_start=1 one cycle,
//            test_count++ -> GUARD.
//   GUARD    2 cycles ignoring busy (encoder busy rises late);
//            test_count==N_TESTS ? DRAIN_W : GEN_DATA.
//   DRAIN_W  count DRAIN cycles with busy==0 -> DONE (busy high resets count).
//   DONE     done=1, hold; only reset exits.
//  data_in/error/err_weight change only in GEN_DATA/GEN_ERR; held constant
//   from ISSUE entry through GUARD.
//  busy high at ISSUE entry: stall indefinitely, no start, outputs stable.
//  enable low mid-run: GEN_* complete current word, ISSUE does not fire.
//  fail: set on any cycle with wrong==1 and reset==0; independent of FSM.
//  Reset mid-operation: immediate return to reset state, partial pattern
//   discarded, no start pulse in the reset cycle or the one after.
//  test_count saturates at N_TESTS; never wraps.
// TESTING
//  1 reset, enable=0 100 cycles -> encode_start never 1, all outputs 0.
//  2 N_TESTS=3, MAX_ERR=2, busy=0 -> 3 starts, popcount(error)=0,1,2 at each
//    start, done after last start+2+DRAIN cycles, test_count=3.
//  3 busy held 1 for 50 cycles in ISSUE -> no start, data_in/error stable;
//    busy->0 -> start next cycle.
//  4 wrong pulsed 1 cycle mid-run -> fail=1 until reset; done still asserts.
//  5 reset asserted during GEN_ERR -> outputs 0 next cycle; rerun reproduces
//    identical data_in/error sequence as run from cold reset (same SEED).
//  6 full loop with sim, P=`BCH_SANE, N_TESTS=64 -> done=1, fail=0.

Source files
------------

// File: rtl/bch_stim_gen.sv
// Stimulus source for the BCH encode/decode loop: LFSR data words plus exact-weight
// error patterns, issued over encode_start/busy, with test counting, drain and status.
module bch_stim_gen #(
  parameter int unsigned B       = 51,
  parameter int unsigned C       = 63,
  parameter int unsigned T       = 2,
  parameter logic [31:0] SEED    = 32'h1,
  parameter int unsigned MAX_ERR = T,
  parameter int unsigned N_TESTS = 64,
  parameter int unsigned DRAIN   = 4 * C
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         busy_i,
  input  logic         wrong_i,
  output logic [B-1:0] data_in_o,
  output logic [C-1:0] error_o,
  output logic         encode_start_o,
  output logic [7:0]   err_weight_o,
  output logic [31:0]  test_count_o,
  output logic         done_o,
  output logic         fail_o
);

  localparam int unsigned NW        = (B + 31) / 32;
  localparam int unsigned WIW       = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned PW        = $clog2(C);
  localparam int unsigned DW        = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [31:0] SEED_L    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN_DATA = 3'd1,
    S_GEN_ERR  = 3'd2,
    S_ISSUE    = 3'd3,
    S_GUARD    = 3'd4,
    S_DRAIN_W  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    lfsr_q, lfsr_d;
  logic [B-1:0]   data_q, data_d;
  logic [C-1:0]   error_q, error_d;
  logic [7:0]     weight_q, weight_d;
  logic [7:0]     wsel_q, wsel_d;
  logic [7:0]     placed_q, placed_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic           guard_q, guard_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [31:0]    count_q, count_d;
  logic           start_q, start_d;
  logic           done_q, done_d;
  logic           fail_q, fail_d;
  logic [PW-1:0]  pos;

  assign pos = lfsr_q[PW-1:0];

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    data_d   = data_q;
    error_d  = error_q;
    weight_d = weight_q;
    wsel_d   = wsel_q;
    placed_d = placed_q;
    widx_d   = widx_q;
    guard_d  = guard_q;
    drain_d  = drain_q;
    count_d  = count_q;
    start_d  = 1'b0;
    done_d   = done_q;
    fail_d   = fail_q | wrong_i;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_GEN_DATA;
          widx_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GEN_DATA: begin
        lfsr_d = lfsr_next(lfsr_q);
        for (int i = 0; i < int'(B); i++) begin
          if (WIW'(i / 32) == widx_q) data_d[i] = lfsr_q[i % 32];
          else                        data_d[i] = data_q[i];
        end
        // The first word of a test also opens a fresh error pattern.
        if (widx_q == '0) begin
          error_d  = '0;
          weight_d = wsel_q;
          placed_d = 8'd0;
        end else begin
          placed_d = placed_q;
        end
        if (widx_q == WIW'(NW - 1)) begin
          widx_d  = '0;
          state_d = (weight_d == 8'd0) ? S_ISSUE : S_GEN_ERR;
        end else begin
          widx_d  = widx_q + 1'b1;
        end
      end
      S_GEN_ERR: begin
        lfsr_d = lfsr_next(lfsr_q);
        if ((32'(pos) < C) && !error_q[pos]) begin
          error_d[pos] = 1'b1;
          placed_d     = placed_q + 8'd1;
          if ((placed_q + 8'd1) == weight_q) state_d = S_ISSUE;
          else                               state_d = S_GEN_ERR;
        end else begin
          placed_d = placed_q;
        end
      end
      S_ISSUE: begin
        if (!busy_i && enable_i) begin
          start_d = 1'b1;
          count_d = (count_q == N_TESTS) ? count_q : count_q + 32'd1;
          wsel_d  = (wsel_q == 8'(MAX_ERR)) ? 8'd0 : wsel_q + 8'd1;
          guard_d = 1'b0;
          state_d = S_GUARD;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_GUARD: begin
        if (guard_q) begin
          drain_d = '0;
          widx_d  = '0;
          state_d = (count_q == N_TESTS) ? S_DRAIN_W : S_GEN_DATA;
        end else begin
          guard_d = 1'b1;
        end
      end
      S_DRAIN_W: begin
        if (busy_i) begin
          drain_d = '0;
        end else if (drain_q == DW'(DRAIN - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_L;
      data_q   <= '0;
      error_q  <= '0;
      weight_q <= 8'd0;
      wsel_q   <= 8'd0;
      placed_q <= 8'd0;
      widx_q   <= '0;
      guard_q  <= 1'b0;
      drain_q  <= '0;
      count_q  <= 32'd0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      data_q   <= data_d;
      error_q  <= error_d;
      weight_q <= weight_d;
      wsel_q   <= wsel_d;
      placed_q <= placed_d;
      widx_q   <= widx_d;
      guard_q  <= guard_d;
      drain_q  <= drain_d;
      count_q  <= count_d;
      start_q  <= start_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign data_in_o      = data_q;
  assign error_o        = error_q;
  assign encode_start_o = start_q;
  assign err_weight_o   = weight_q;
  assign test_count_o   = count_q;
  assign done_o         = done_q;
  assign fail_o         = fail_q;

endmodule
